// File: rtl/znmi_retn.sv
// znmi_retn: watches Z80 opcode fetches for the ED-prefixed RETN family while
// in NMI mode and, once RETN has popped its return address, emits a single
// fclk clr_nmi pulse so the NMI RAM page can be unmapped.
module znmi_retn #(
    parameter int unsigned POP_CYCLES = 2   // stack pops before the clear, 1..3
) (
    input  logic       fclk,
    input  logic       rst,
    input  logic       zpos,
    input  logic       zneg,
    input  logic       m1_n,
    input  logic       mreq_n,
    input  logic       rd_n,
    input  logic       rfsh_n,
    input  logic [7:0] d,
    input  logic       in_nmi,
    input  logic       retn_en,
    output logic       clr_nmi,
    output logic       armed,
    output logic [1:0] state_dbg
);

    localparam int unsigned CNT_W = 2;
    localparam int unsigned OP_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GOT_ED = 2'b01,
        ARMED  = 2'b10
    } state_t;

    logic [OP_W-1:0]  opcode;
    logic             fetch_act;
    logic             op_strobe;
    logic             mreq_q;
    logic             mem_done;
    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] pop_cnt;
    logic [CNT_W-1:0] pop_nx;
    logic [CNT_W-1:0] pop_inc;
    logic             clr_nx;
    logic             is_ed;
    logic             is_retn;

    assign is_ed     = (opcode == 8'hED);
    // 45,55,5D,65,6D,75,7D all behave as RETN; 4D is RETI and must not clear NMI
    assign is_retn   = ((opcode & 8'hC7) == 8'h45) && (opcode != 8'h4D);
    assign pop_inc   = pop_cnt + CNT_W'(1);
    assign state_dbg = state;

    // Latch the opcode on an M1 memory read; strobe once M1 is released
    always_ff @(posedge fclk) begin
        if (rst) begin
            opcode    <= '0;
            fetch_act <= 1'b0;
            op_strobe <= 1'b0;
        end else begin
            op_strobe <= 1'b0;
            if (zpos) begin
                if (!m1_n && !mreq_n && !rd_n) begin
                    opcode    <= d;
                    fetch_act <= 1'b1;
                end else if (m1_n && fetch_act) begin
                    fetch_act <= 1'b0;
                    op_strobe <= 1'b1;
                end
            end
        end
    end

    // A rising MREQ seen at zneg outside M1/refresh marks one finished memory cycle
    always_ff @(posedge fclk) begin
        if (rst) begin
            mreq_q   <= 1'b0;
            mem_done <= 1'b0;
        end else begin
            mem_done <= 1'b0;
            if (zneg) begin
                mreq_q <= mreq_n;
                if (mreq_n && !mreq_q && m1_n && rfsh_n) begin
                    mem_done <= 1'b1;
                end
            end
        end
    end

    // FSM state, pop counter and registered outputs
    always_ff @(posedge fclk) begin
        if (rst) begin
            state   <= IDLE;
            pop_cnt <= '0;
            clr_nmi <= 1'b0;
            armed   <= 1'b0;
        end else begin
            state   <= state_nx;
            pop_cnt <= pop_nx;
            clr_nmi <= clr_nx;
            armed   <= (state_nx == ARMED);
        end
    end

    // Next-state decode; a fetch while armed is decoded as a fresh opcode
    always_comb begin
        state_nx = state;
        pop_nx   = pop_cnt;
        clr_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (op_strobe && is_ed) begin
                    state_nx = GOT_ED;
                end
            end
            GOT_ED: begin
                if (op_strobe) begin
                    if (is_retn && in_nmi && retn_en) begin
                        state_nx = ARMED;
                        pop_nx   = '0;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            ARMED: begin
                if (op_strobe) begin
                    state_nx = is_ed ? GOT_ED : IDLE;
                end else if (!in_nmi || !retn_en) begin
                    state_nx = IDLE;
                end else if (mem_done) begin
                    if (pop_inc == CNT_W'(POP_CYCLES)) begin
                        clr_nx   = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        pop_nx = pop_inc;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule
